somador_serial: RTL and testbench
=================================

Name: somador_serial

Overview:
Bit-serial N-bit adder for the ULA, the additive counterpart of the ripple subtractor. One full-adder cell is reused over WIDTH clock cycles, LSB first, with a carry flip-flop in the loop. A start/busy/done handshake lets the ULA control sequencer launch an addition and collect the sum, carry-out and signed overflow. Area is traded for latency.

Parameters:
WIDTH, 8, operand and sum width in bits (minimum 2).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; sampled on the accepted start edge
b  input  WIDTH  operand B; sampled on the accepted start edge
cin  input  1  carry-in; sampled on the accepted start edge
busy  output  1  high while state is RUN or DONE
done  output  1  one-cycle pulse; result valid
s  output  WIDTH  sum a+b+cin mod 2^WIDTH
cout  output  1  carry out of the MSB
overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset: when rst=1 at a clk edge, state goes to IDLE and busy, done, s, cout and overflow all go to 0. The operand shift registers, carry flip-flop and bit counter also clear.
- Reset mid-operation: an addition in progress is aborted and no done is produced. rst has priority over start.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - With start=1 at edge N, latch a into shift register ra, b into rb and cin into the carry flip-flop.
  - Clear the bit counter and the sum shift register, then go to RUN.
  - With start=0, remain in IDLE.
- RUN (edges N+1 .. N+WIDTH):
  - Each edge computes full-adder(ra[0], rb[0], carry).
  - The sum bit shifts into the sum register from the MSB side. ra and rb shift right. The carry flip-flop takes the cell carry.
  - The counter increments each edge.
  - On the edge that processes bit WIDTH-1:
    - Record overflow = (carry into that cell) XOR (carry out of that cell).
    - Transfer the sum register to s and the final carry to cout.
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then the next edge returns to IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle following edge N+WIDTH. Total is WIDTH+1 edges from start to done. The earliest next accepted start is edge N+WIDTH+2.
- start while busy=1 (RUN or DONE) is ignored. Operands are not re-sampled and there is no queueing.
- s, cout and overflow keep their values from the DONE transfer until the next completed addition or reset. They do not change during a subsequent RUN.
- Arithmetic is unsigned modular with carry-out. overflow is the two's-complement interpretation.
- start held high continuously runs back-to-back additions. Each operand pair is sampled in IDLE.
- The bit counter is $clog2(WIDTH) bits wide and wraps only via the IDLE clear.

Decomposition:
- Package ula_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} somador_estado_t
  - localparam ULA_WIDTH = 8, shared with the other ULA blocks
- Sub-module somadorcompleto (1-bit full adder: a, b, cin -> s, cout) is instantiated once as the serial cell. It is the additive twin of subtradorcompleto.

Test Plan:
- Reset, then a=100, b=27, cin=0, start pulse at edge N -> busy=1 from N. done=1 in the cycle after edge N+8 (WIDTH=8). s=127, cout=0, overflow=0.
- a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, overflow=0.
- a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, overflow=1. Also a=8'h80, b=8'h80, cin=0 -> s=8'h00, cout=1, overflow=1.
- a=0, b=0, cin=1 -> s=1, cout=0. Then a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1, overflow=0.
- Start 5+3; pulse start with a=9, b=9 at edge N+3 (RUN) -> the second start is ignored. Result s=8, done pulses once, idle afterwards.
- Start 200+100; assert rst at edge N+4 -> no done. All outputs are 0 the cycle after the reset edge. A new start after reset (20+22) yields s=42.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared ULA definitions: serial adder state encoding and the common datapath width.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } somador_estado_t;

    localparam int ULA_WIDTH = 8;

endpackage : ula_pkg

// File: rtl/somadorcompleto.sv
// One-bit full adder; reused every cycle as the cell of the bit-serial adder.
module somadorcompleto (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : somadorcompleto

// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell processes the operands LSB first over WIDTH
// cycles, with a start/busy/done handshake and registered sum, carry-out and overflow.
module somador_serial
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    somador_estado_t  state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;

    somadorcompleto u_cell (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state, datapath and registered-output logic for the serial addition.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    cnt_d   = {CNT_W{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                ra_d    = {1'b0, ra_q[WIDTH-1:1]};
                rb_d    = {1'b0, rb_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // Overflow compares the carry entering and leaving the sign cell.
                if (cnt_q == LAST_BIT) begin
                    s_d     = {fa_s, sum_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= {WIDTH{1'b0}};
            rb_q    <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule : somador_serial

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: directed corner cases plus random additions
// compared against plain integer arithmetic.
module tb_somador_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         overflow;

    int n_total;
    int n_bad;

    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         prev_v;

    somador_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One addition; inj_at>0 pulses a stray start at edge N+inj_at, rst_at>0 resets at N+rst_at.
    task automatic run_add(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                           input int inj_at, input int rst_at);
        logic [W:0]   full;
        logic [W-1:0] exp_s;
        logic         exp_c;
        logic         exp_v;
        int           first_done;
        int           n_done;
        logic [W-1:0] got_s;
        logic         got_c;
        logic         got_v;

        full  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
        exp_s = full[W-1:0];
        exp_c = full[W];
        exp_v = (aa[W-1] == bb[W-1]) && (exp_s[W-1] != aa[W-1]);
        first_done = -1;
        n_done     = 0;
        got_s = '0; got_c = 1'b0; got_v = 1'b0;

        @(negedge clk);
        start = 1'b1; a = aa; b = bb; cin = ci;
        @(posedge clk); #1;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        check_eq("done_at_start", {31'd0, done}, 32'd0);

        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            start = (i == inj_at);
            if (i == inj_at) begin
                a = 8'd9; b = 8'd9; cin = 1'b0;
            end
            rst = (i == rst_at);
            @(posedge clk); #1;
            if (i == 1) begin
                check_eq("s_held_in_run", {24'd0, s}, {24'd0, prev_s});
                check_eq("cout_held_in_run", {31'd0, cout}, {31'd0, prev_c});
            end
            if (i == rst_at) begin
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_done", {31'd0, done}, 32'd0);
                check_eq("rst_s", {24'd0, s}, 32'd0);
                check_eq("rst_cout", {31'd0, cout}, 32'd0);
                check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
            end
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = i;
                    got_s = s; got_c = cout; got_v = overflow;
                end
            end
        end
        rst = 1'b0;
        start = 1'b0;

        check_eq("idle_after", {31'd0, busy}, 32'd0);
        if (rst_at > 0) begin
            check_eq("no_done_after_rst", n_done, 32'd0);
            prev_s = '0; prev_c = 1'b0; prev_v = 1'b0;
        end else begin
            check_eq("done_count", n_done, 32'd1);
            check_eq("done_latency", first_done, W);
            check_eq("sum", {24'd0, got_s}, {24'd0, exp_s});
            check_eq("cout", {31'd0, got_c}, {31'd0, exp_c});
            check_eq("overflow", {31'd0, got_v}, {31'd0, exp_v});
            check_eq("s_holds", {24'd0, s}, {24'd0, exp_s});
            prev_s = exp_s; prev_c = exp_c; prev_v = exp_v;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_s = '0; prev_c = 1'b0; prev_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_s", {24'd0, s}, 32'd0);
        check_eq("reset_cout", {31'd0, cout}, 32'd0);
        check_eq("reset_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_add(8'd100, 8'd27, 1'b0, 0, 0);
        run_add(8'hFF, 8'h01, 1'b0, 0, 0);
        run_add(8'h7F, 8'h01, 1'b0, 0, 0);
        run_add(8'h80, 8'h80, 1'b0, 0, 0);
        run_add(8'h00, 8'h00, 1'b1, 0, 0);
        run_add(8'hFF, 8'hFF, 1'b1, 0, 0);
        run_add(8'd5, 8'd3, 1'b0, 3, 0);
        run_add(8'd200, 8'd100, 1'b0, 0, 4);
        run_add(8'd20, 8'd22, 1'b0, 0, 0);

        for (int k = 0; k < 20; k++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_somador_serial
